// File: rtl/conv1_pkg.sv
// Shared types and widths for the 5-tap 1-D convolution controller.
package conv1_pkg;
    localparam int TAPS = 5;
    localparam int XW   = 8;
    localparam int WW   = 8;
    localparam int PW   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOADW,
        STREAM,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/conv1_vdly.sv
// Valid delay line: din reappears on dout LAT cycles later; cleared by reset.
module conv1_vdly #(
    parameter int LAT = 5
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic din,
    output logic dout
);
    logic [LAT-1:0] vld_pipe;
    logic [LAT:0]   vld_nxt;

    assign vld_nxt = {vld_pipe, din};
    assign dout    = vld_pipe[LAT-1];

    always_ff @(posedge iCLK) begin
        if (!iRSTn) vld_pipe <= '0;
        else        vld_pipe <= vld_nxt[LAT-1:0];
    end
endmodule

// File: rtl/conv1_ctrl.sv
// Run controller for a 5-tap 1-D convolution datapath: weight load, sample
// streaming with gap detection, result qualification and run bookkeeping.
module conv1_ctrl
    import conv1_pkg::*;
#(
    parameter int LEN = 32,
    parameter int LAT = 5
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iStart,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oErr,
    input  logic                 iWValid,
    input  logic signed [WW-1:0] iWData,
    output logic signed [WW-1:0] oW1,
    output logic signed [WW-1:0] oW2,
    output logic signed [WW-1:0] oW3,
    output logic signed [WW-1:0] oW4,
    output logic signed [WW-1:0] oW5,
    input  logic                 iXValid,
    input  logic signed [XW-1:0] iXData,
    input  logic signed [PW-1:0] iPsumData,
    output logic                 oXReady,
    output logic signed [XW-1:0] oX,
    output logic signed [PW-1:0] oPsum,
    input  logic signed [PW-1:0] iYData,
    output logic                 oYValid,
    output logic signed [PW-1:0] oYData,
    output logic [7:0]           oYCnt
);
    state_t state, nstate;

    logic [TAPS-1:0][WW-1:0] w;
    logic [2:0]              wcnt;
    logic [7:0]              xcnt;
    logic [7:0]              dcnt;
    logic                    xfer, gap, accept, xv, ydv;

    assign oW1 = w[0];
    assign oW2 = w[1];
    assign oW3 = w[2];
    assign oW4 = w[3];
    assign oW5 = w[4];

    assign accept = (state == IDLE) && iStart;
    assign xfer   = oXReady && iXValid;
    // Waiting before the first sample is legal; a hole after it breaks the window.
    assign gap    = oXReady && !iXValid && (xcnt != 8'd0);

    always_ff @(posedge iCLK) begin
        if (!iRSTn) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate  = state;
        oBusy   = 1'b1;
        oDone   = 1'b0;
        oXReady = 1'b0;
        case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (iStart) nstate = LOADW;
            end
            LOADW: begin
                if (iWValid && wcnt == 3'(TAPS-1)) nstate = STREAM;
            end
            STREAM: begin
                oXReady = 1'b1;
                if (!iXValid && xcnt != 8'd0)            nstate = DRAIN;
                else if (iXValid && xcnt == 8'(LEN-1))   nstate = DRAIN;
            end
            DRAIN: begin
                if (dcnt == 8'(LAT)) nstate = DONE;
            end
            DONE: begin
                oDone  = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            w       <= '0;
            wcnt    <= '0;
            xcnt    <= '0;
            dcnt    <= '0;
            oX      <= '0;
            oPsum   <= '0;
            xv      <= 1'b0;
            oYValid <= 1'b0;
            oYData  <= '0;
            oYCnt   <= '0;
            oErr    <= 1'b0;
        end else begin
            if (state == LOADW && iWValid) begin
                w[wcnt] <= iWData;
                wcnt    <= (wcnt == 3'(TAPS-1)) ? 3'd0 : wcnt + 3'd1;
            end

            if (accept)    xcnt <= '0;
            else if (xfer) xcnt <= xcnt + 8'd1;

            dcnt <= (state == DRAIN) ? dcnt + 8'd1 : 8'd0;

            oX    <= xfer ? iXData    : '0;
            oPsum <= xfer ? iPsumData : '0;
            // Only full windows (5th sample onward) produce a result.
            xv    <= xfer && (xcnt >= 8'(TAPS-1));

            oYValid <= ydv;
            oYData  <= ydv ? iYData : '0;

            if (accept)                       oYCnt <= '0;
            else if (ydv && oYCnt != 8'hFF)   oYCnt <= oYCnt + 8'd1;

            if (accept)   oErr <= 1'b0;
            else if (gap) oErr <= 1'b1;
        end
    end

    conv1_vdly #(.LAT(LAT)) u_vdly (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .din   (xv),
        .dout  (ydv)
    );
endmodule

// File: tb/tb_conv1_ctrl.sv
// Directed bench for conv1_ctrl with a behavioural 5-tap MAC+saturate datapath.
module tb_conv1_ctrl;
    localparam int LEN = 8;
    localparam int LAT = 5;

    logic iCLK, iRSTn, iStart, iWValid, iXValid;
    logic oBusy, oDone, oErr, oXReady, oYValid;
    logic signed [7:0]  iWData, iXData, oW1, oW2, oW3, oW4, oW5, oX;
    logic signed [15:0] iPsumData, oPsum, iYData, oYData;
    logic [7:0]         oYCnt;

    int nchk = 0;
    int nfail = 0;

    conv1_ctrl #(.LEN(LEN), .LAT(LAT)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
        .oErr(oErr), .iWValid(iWValid), .iWData(iWData), .oW1(oW1), .oW2(oW2),
        .oW3(oW3), .oW4(oW4), .oW5(oW5), .iXValid(iXValid), .iXData(iXData),
        .iPsumData(iPsumData), .oXReady(oXReady), .oX(oX), .oPsum(oPsum),
        .iYData(iYData), .oYValid(oYValid), .oYData(oYData), .oYCnt(oYCnt)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Datapath model: window of the last five presented operands, W1 on the oldest.
    logic signed [7:0]  win   [4];
    logic signed [15:0] ypipe [LAT];
    assign iYData = ypipe[LAT-1];

    always @(posedge iCLK) begin
        int acc;
        logic signed [15:0] sat;
        if (!iRSTn) begin
            for (int i = 0; i < 4; i++)   win[i]   <= '0;
            for (int i = 0; i < LAT; i++) ypipe[i] <= '0;
        end else begin
            acc = int'(oPsum) + int'(oW5) * int'(oX) + int'(oW4) * int'(win[0])
                + int'(oW3) * int'(win[1]) + int'(oW2) * int'(win[2]) + int'(oW1) * int'(win[3]);
            if (acc > 32767)       sat = 16'sh7FFF;
            else if (acc < -32768) sat = 16'sh8000;
            else                   sat = 16'(acc);
            ypipe[0] <= sat;
            for (int i = 1; i < LAT; i++) ypipe[i] <= ypipe[i-1];
            win[0] <= oX;
            for (int i = 1; i < 4; i++) win[i] <= win[i-1];
        end
    end

    typedef struct {
        logic [4:0][7:0] w;
        logic [7:0]      x;
        logic [15:0]     psum;
        int              gap_at;
        int              delay;
        bit              poke;
        longint          ey;
        int              nres;
        bit              err;
    } scn_t;

    scn_t tbl [7];

    function automatic scn_t mk(input logic [39:0] w, input logic [7:0] x, input logic [15:0] psum,
                                input int gap_at, input int delay, input bit poke,
                                input longint ey, input int nres, input bit err);
        scn_t s;
        s.w = w; s.x = x; s.psum = psum; s.gap_at = gap_at; s.delay = delay;
        s.poke = poke; s.ey = ey; s.nres = nres; s.err = err;
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input int id);
        chk($sformatf("r%0d_w", id), {oW5, oW4, oW3, oW2, oW1}, 0);
        chk($sformatf("r%0d_xp", id), {oX, oPsum}, 0);
        chk($sformatf("r%0d_y", id), {oYData, oYCnt}, 0);
        chk($sformatf("r%0d_flags", id), {oYValid, oDone, oErr, oBusy, oXReady}, 0);
    endtask

    task automatic start_load(input scn_t s, input int id);
        iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        chk($sformatf("s%0d_err_clr", id), oErr, 0);
        chk($sformatf("s%0d_busy", id), oBusy, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                iWValid = 1'b0;
                @(posedge iCLK); #1;
            end
            iWValid = 1'b1;
            iWData  = s.w[i];
            @(posedge iCLK); #1;
        end
        iWValid = 1'b0;
        chk($sformatf("s%0d_wload", id), {oW5, oW4, oW3, oW2, oW1}, s.w);
        chk($sformatf("s%0d_xrdy", id), oXReady, 1);
    endtask

    task automatic run_scn(input scn_t s, input int id);
        int sent, cyc, nres, ndone, wait_n;
        longint ycnt_done, err_done, w_done;
        bit fin;
        sent = 0; cyc = 0; nres = 0; ndone = 0; wait_n = s.delay; fin = 1'b0;
        ycnt_done = -1; err_done = -1; w_done = -1;
        start_load(s, id);
        while (!fin && cyc < 300) begin
            iStart = 1'b0; iWValid = 1'b0; iXValid = 1'b0;
            if (oXReady) begin
                if (wait_n > 0) wait_n--;
                else if (sent < s.gap_at) begin
                    iXValid = 1'b1; iXData = s.x; iPsumData = s.psum; sent++;
                    if (s.poke && sent == 2) begin
                        iStart = 1'b1; iWValid = 1'b1; iWData = 8'sd99;
                    end
                end
            end
            @(posedge iCLK); #1;
            cyc++;
            if (oYValid) begin
                nres++;
                chk($sformatf("s%0d_y%0d", id, nres), longint'(oYData), s.ey);
            end
            if (oDone) begin
                ndone++;
                ycnt_done = oYCnt; err_done = oErr; w_done = {oW5, oW4, oW3, oW2, oW1};
            end else if (ndone > 0) fin = 1'b1;
        end
        iStart = 1'b0; iWValid = 1'b0; iXValid = 1'b0;
        chk($sformatf("s%0d_finished", id), fin, 1);
        chk($sformatf("s%0d_nres", id), nres, s.nres);
        chk($sformatf("s%0d_done_len", id), ndone, 1);
        chk($sformatf("s%0d_ycnt", id), ycnt_done, s.nres);
        chk($sformatf("s%0d_err", id), err_done, s.err);
        chk($sformatf("s%0d_whold", id), w_done, s.w);
        chk($sformatf("s%0d_idle", id), oBusy, 0);
    endtask

    task automatic reset_mid(input int n);
        int cnt;
        cnt = 0;
        start_load(tbl[0], 90 + n);
        for (int k = 1; k <= n; k++) begin
            iXValid = 1'b1; iXData = 8'sd1; iPsumData = '0;
            if (k == n) iRSTn = 1'b0;
            @(posedge iCLK); #1;
        end
        iXValid = 1'b0;
        check_zero(n);
        iRSTn = 1'b1;
        repeat (20) begin
            @(posedge iCLK); #1;
            if (oYValid) cnt++;
        end
        chk($sformatf("r%0d_no_y", n), cnt, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRSTn = 1'b0; iStart = 1'b0; iWValid = 1'b0; iWData = '0;
        iXValid = 1'b0; iXData = '0; iPsumData = '0;

        tbl[0] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd1,   16'd0,      LEN, 0, 1'b0, 15,     4, 1'b0);
        tbl[1] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd1,   16'hFFEC,   LEN, 0, 1'b0, -5,     4, 1'b0);
        tbl[2] = mk({5{8'd127}},                    8'd127, 16'd0,      LEN, 0, 1'b0, 32767,  4, 1'b0);
        tbl[3] = mk({5{8'h80}},                     8'd127, 16'd0,      LEN, 0, 1'b0, -32768, 4, 1'b0);
        tbl[4] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd1,   16'd0,      6,   0, 1'b0, 15,     2, 1'b1);
        tbl[5] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd1,   16'd0,      LEN, 0, 1'b1, 15,     4, 1'b0);
        tbl[6] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd1,   16'd0,      LEN, 3, 1'b0, 15,     4, 1'b0);

        repeat (3) @(posedge iCLK);
        #1;
        check_zero(0);
        iRSTn = 1'b1;
        @(posedge iCLK); #1;
        chk("idle_busy", oBusy, 0);
        chk("idle_xrdy", oXReady, 0);

        for (int i = 0; i < 7; i++) run_scn(tbl[i], i);

        reset_mid(4);
        run_scn(tbl[0], 10);
        reset_mid(6);
        run_scn(tbl[0], 11);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
